// File: rtl/key_loader.sv
// key_loader: serial ready/valid key intake for the locked c432 netlists, driving p1..p4 / X_1..X_25.
// Define KEY_LOADER_CRC_EN to append and check a CRC-8 (poly 0x07, MSB first) after the key bits.
module key_loader #(
  parameter int KEY_W = 29,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             key_bit_valid,
  input  logic             key_bit,
  output logic             key_bit_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_KEY = 3'd1,
`ifdef KEY_LOADER_CRC_EN
    SHIFT_CRC = 3'd2,
`endif
    CHECK     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] shreg;
  logic             xfer;
  logic             load;
  logic             last_key;
  logic             match;

  assign xfer     = key_bit_valid && key_bit_ready;
  assign load     = !clear && start && ((state == IDLE) || (state == DONE));
  assign last_key = (cnt == CNT_W'(KEY_W - 1));

`ifdef KEY_LOADER_CRC_EN
  logic [7:0] crc;
  logic [7:0] rx_crc;
  logic       error_q;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Running CRC over key bits, received CRC captured MSB first
  always_ff @(posedge clk) begin
    if (load) begin
      crc    <= '0;
      rx_crc <= '0;
    end else if (xfer && (state == SHIFT_KEY)) begin
      crc <= crc8_step(crc, key_bit);
    end else if (xfer && (state == SHIFT_CRC)) begin
      rx_crc <= {rx_crc[6:0], key_bit};
    end
  end

  assign match = (rx_crc == crc);
  assign error = error_q;
`else
  assign match = 1'b1;
  assign error = 1'b0;
`endif

  // Key assembly; only exposed on key_out after CHECK accepts it
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= '0;
    end else if (xfer && (state == SHIFT_KEY)) begin
      shreg[cnt] <= key_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      key_out       <= '0;
      key_valid     <= 1'b0;
      busy          <= 1'b0;
      key_bit_ready <= 1'b0;
`ifdef KEY_LOADER_CRC_EN
      error_q       <= 1'b0;
`endif
    end else if (clear) begin
      state         <= IDLE;
      cnt           <= '0;
      key_out       <= '0;
      key_valid     <= 1'b0;
      busy          <= 1'b0;
      key_bit_ready <= 1'b0;
`ifdef KEY_LOADER_CRC_EN
      error_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= SHIFT_KEY;
            cnt           <= '0;
            key_out       <= '0;
            key_valid     <= 1'b0;
            busy          <= 1'b1;
            key_bit_ready <= 1'b1;
`ifdef KEY_LOADER_CRC_EN
            error_q       <= 1'b0;
`endif
          end
        end
        SHIFT_KEY: begin
          if (xfer) begin
            if (last_key) begin
              cnt <= '0;
`ifdef KEY_LOADER_CRC_EN
              state <= SHIFT_CRC;
`else
              state         <= CHECK;
              key_bit_ready <= 1'b0;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
`ifdef KEY_LOADER_CRC_EN
        SHIFT_CRC: begin
          if (xfer) begin
            if (cnt == CNT_W'(7)) begin
              cnt           <= '0;
              state         <= CHECK;
              key_bit_ready <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
`endif
        CHECK: begin
          busy <= 1'b0;
          if (match) begin
            key_out   <= shreg;
            key_valid <= 1'b1;
            state     <= DONE;
          end else begin
`ifdef KEY_LOADER_CRC_EN
            error_q <= 1'b1;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
